mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I core variant that shares one memory port between instruction fetch and load/store.
- Steps the datapath through fetch, decode, execute, memory and writeback states; one instruction completes every 3-5 states.
- Drives the mux selects and write strobes of the shared ALU, the PC, the IR and the register file.
- Waits on a memory ready handshake; traps on unsupported encodings.

Parameters:
ST_W, 4, width of the state encoding and of the state_o debug port.
CNT_W, 32, width of the performance counters (only used with PERF_CNT_EN).

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
instr  in  32  IR contents; valid from DECODE onward.
mem_ready  in  1  memory access completes in any cycle where mem_ready=1 and a request is asserted.
EQ  in  1  ALU equality flag (rs1==rs2).
LT  in  1  ALU less-than flag; signed/unsigned already selected by funct3 in the ALU decoder.
MemRead  out  1  memory read request.
MemWrite  out  1  memory write request.
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
IRWrite  out  1  load IR (and OldPC) from memory data.
PCWrite  out  1  load PC from the Result bus.
RegWrite  out  1  register file write enable.
ResultSrc  out  2  result select: 00=ALUOut, 01=mem data, 10=ALU direct.
ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1, 11=zero.
ALUSrcB  out  2  ALU B select: 00=rs2, 01=imm, 10=const 4.
ALUOp  out  2  00=add, 01=branch compare, 10=funct decode.
ImmSrc  out  3  000=I, 001=S, 010=B, 011=U, 100=J.
trap  out  1  sticky illegal-instruction flag.
state_o  out  ST_W  current state, for debug.
cycle_cnt  out  CNT_W  cycle counter (PERF_CNT_EN).
instret_cnt  out  CNT_W  retired-instruction counter (PERF_CNT_EN).

Behaviour:
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13, TRAP=14. Code 15 is unreachable and recovers to FETCH.
- Outputs are combinational from state, except IRWrite/PCWrite in FETCH and PCWrite in BRANCH. Any field not listed below is 0.
- Reset: state=FETCH; while rst is high every strobe is forced to 0 and trap=0. Reset mid-access abandons the access; no PC or IR update occurs.
- FETCH:
  - MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - If mem_ready: IRWrite=1 and PCWrite=1 in the same cycle, then -> DECODE. Otherwise hold FETCH with all outputs stable.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (target is latched in ALUOut). ImmSrc=100 for jal, else 010.
  - Dispatch on opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, 0010111->AUIPC. Any other opcode -> TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000 (load) or 001 (store). Load -> MEMREAD, store -> MEMWRITE.
- MEMREAD: MemRead=1, AdrSrc=1. Stays until mem_ready, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then -> FETCH.
- MEMWRITE: MemWrite=1, AdrSrc=1. Stays until mem_ready, then -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=10, then -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then -> FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. Then -> FETCH.
  - PCWrite by funct3: 000=EQ, 001=!EQ, 100/110=LT, 101/111=!LT.
  - funct3 010/011 -> TRAP, with PCWrite=0.
- JAL: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10 (OldPC+4 latched into ALUOut), then -> ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, then -> JAL. The datapath clears target bit 0.
- LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc=011, then -> ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=011, then -> ALUWB.
- TRAP: all strobes 0, trap=1. Absorbing; only rst exits.
- Handshake rules:
  - mem_ready is ignored when no request is asserted.
  - mem_ready held permanently high gives zero-wait accesses.
  - MemRead and MemWrite are never asserted together.
- Latency with zero-wait memory, FETCH entry to next FETCH: branch 3, R/I/store/lui/auipc/jal 4, load/jalr 5.

Optional Feature:
PERF_CNT_EN:
- Defined: cycle_cnt increments every non-reset cycle. instret_cnt increments on every transition into FETCH from a non-FETCH state. Both wrap modulo 2^CNT_W and reset to 0.
- Not defined: no counter flops; both ports are tied to 0.

Test Plan:
- mem_ready=1, instr=add x3,x1,x2 (0x002081B3) -> states 0,1,6,8,0. RegWrite=1 only in the ALUWB cycle.
- lw x5,8(x1) with mem_ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles with MemRead=1, AdrSrc=1, then MEMWB with ResultSrc=01, RegWrite=1. Fetch stalls likewise: no IRWrite until mem_ready.
- beq, EQ=1 -> PCWrite=1 in BRANCH. bne, EQ=1 -> PCWrite=0. blt, LT=1 -> PCWrite=1. 3 cycles per branch.
- jalr x1,0(x5) -> states 0,1,11,10,8,0. PCWrite=1 in JAL; RegWrite=1 in ALUWB.
- instr=0xFFFFFFFF -> DECODE then TRAP, trap=1, no strobes. Stays in TRAP for 100 cycles; rst pulse -> FETCH, trap=0.
- PERF_CNT_EN defined, 3 zero-wait adds -> instret_cnt=3, cycle_cnt=12. Asynchronous rst mid-EXECR -> both counters and state_o=0 immediately.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: one shared memory port serves instruction fetch and load/store.
// Define PERF_CNT_EN to build the cycle and retired-instruction counters; otherwise both ports read 0.
module mc_ctrl_fsm #(
  parameter int ST_W  = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             EQ,
  input  logic             LT,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             trap,
  output logic [ST_W-1:0]  state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t     state_q;
  state_t     state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       br_take;
  logic       br_illegal;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  // Opcode dispatch out of DECODE; anything unrecognised is an illegal instruction.
  function automatic state_t dispatch(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return S_MEMADR;
      OP_RTYPE:          return S_EXECR;
      OP_ITYPE:          return S_EXECI;
      OP_BRANCH:         return S_BRANCH;
      OP_JAL:            return S_JAL;
      OP_JALR:           return S_JALR;
      OP_LUI:            return S_LUI;
      OP_AUIPC:          return S_AUIPC;
      default:           return S_TRAP;
    endcase
  endfunction

  // The ALU has already applied signed/unsigned semantics to LT, so only polarity is chosen here.
  always_comb begin
    br_take    = 1'b0;
    br_illegal = 1'b0;
    case (funct3)
      3'b000:         br_take = EQ;
      3'b001:         br_take = ~EQ;
      3'b100, 3'b110: br_take = LT;
      3'b101, 3'b111: br_take = ~LT;
      default:        br_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ImmSrc    = 3'b000;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_JAL) ? 3'b100 : 3'b010;
        state_d = dispatch(opcode);
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        // opcode bit 5 separates store (0100011) from load (0000011)
        ImmSrc  = opcode[5] ? 3'b001 : 3'b000;
        state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = br_take & ~br_illegal;
        state_d = br_illegal ? S_TRAP : S_FETCH;
      end
      S_JAL: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b011;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b011;
        state_d = S_ALUWB;
      end
      S_TRAP: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset silences the datapath at once, abandoning any in-flight access.
    if (rst) begin
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      ImmSrc    = 3'b000;
      trap      = 1'b0;
    end
  end

  assign state_o = ST_W'(state_q);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle expected control vectors queued from the state table, checked each cycle.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        EQ;
  logic        LT;
  logic        MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, trap;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]  ImmSrc;
  logic [3:0]  state_o;
  logic [31:0] cycle_cnt, instret_cnt;

  int n_pass  = 0;
  int n_total = 0;
  logic [21:0] exp_q[$];

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
  localparam logic [3:0] XR = 4'd6, XI = 4'd7, AWB = 4'd8, BR = 4'd9, JL = 4'd10, JR = 4'd11;
  localparam logic [3:0] LU = 4'd12, AU = 4'd13, TR = 4'd14;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .EQ(EQ), .LT(LT),
    .MemRead(MemRead), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .trap(trap), .state_o(state_o),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs per state, straight from the control table; pcw/irw/imm carry the input-dependent fields.
  function automatic logic [21:0] ev(input logic [3:0] st, input logic pcw, input logic irw,
                                     input logic [2:0] imm);
    logic mr, mw, adr, rw, tr, p, i;
    logic [1:0] rs, a, b, op;
    logic [2:0] im;
    {mr, mw, adr, rw, tr, p, i} = '0;
    rs = 2'b00; a = 2'b00; b = 2'b00; op = 2'b00; im = 3'b000;
    case (st)
      F:   begin mr = 1; b = 2'b10; rs = 2'b10; p = pcw; i = irw; end
      D:   begin a = 2'b01; b = 2'b01; im = imm; end
      MA:  begin a = 2'b10; b = 2'b01; im = imm; end
      MR:  begin mr = 1; adr = 1; end
      MWB: begin rs = 2'b01; rw = 1; end
      MW:  begin mw = 1; adr = 1; end
      XR:  begin a = 2'b10; op = 2'b10; end
      XI:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      AWB: rw = 1;
      BR:  begin a = 2'b10; op = 2'b01; p = pcw; end
      JL:  begin p = 1; a = 2'b01; b = 2'b10; end
      JR:  begin a = 2'b10; b = 2'b01; end
      LU:  begin a = 2'b11; b = 2'b01; im = 3'b011; end
      AU:  begin a = 2'b01; b = 2'b01; im = 3'b011; end
      TR:  tr = 1;
      default: ;
    endcase
    return {st, mr, mw, adr, i, p, rw, rs, a, b, op, im, tr};
  endfunction

  task automatic chk(input string tag);
    logic [21:0] exp, obs;
    @(negedge clk);
    obs = {state_o, MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, trap};
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 22'h3FFFFF;
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic pcw, input logic irw,
                      input logic [2:0] imm);
    exp_q.push_back(ev(st, pcw, irw, imm));
    chk(tag);
  endtask

  task automatic step_rst(input string tag);
    exp_q.push_back(22'h0);
    chk(tag);
  endtask

  task automatic cmp32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [31:0] br_ins [7] = '{32'h00208063, 32'h00209063, 32'h0020C063, 32'h0020D063,
                              32'h0020E063, 32'h0020F063, 32'h00208063};
  logic        br_eq  [7] = '{1, 1, 0, 0, 0, 0, 0};
  logic        br_lt  [7] = '{0, 0, 1, 1, 0, 0, 1};
  logic        br_tk  [7] = '{1, 0, 1, 0, 0, 1, 0};

  initial begin
    rst = 1'b1; mem_ready = 1'b0; instr = 32'h0; EQ = 1'b0; LT = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step_rst("reset");
    rst = 1'b0;

    // three zero-wait adds
    mem_ready = 1'b1; instr = 32'h002081B3;
    for (int k = 0; k < 3; k++) begin
      step("add_fetch", F, 1, 1, 3'b000);
      step("add_decode", D, 0, 0, 3'b010);
      step("add_execr", XR, 0, 0, 3'b000);
      step("add_aluwb", AWB, 0, 0, 3'b000);
    end
`ifdef PERF_CNT_EN
    cmp32("instret_after_3_adds", instret_cnt, 32'd3);
    cmp32("cycles_after_3_adds", cycle_cnt, 32'd12);
`endif
    step("add4_fetch", F, 1, 1, 3'b000);
    step("add4_decode", D, 0, 0, 3'b010);
    rst = 1'b1;
    step_rst("rst_mid_execr");
`ifdef PERF_CNT_EN
    cmp32("instret_after_rst", instret_cnt, 32'd0);
    cmp32("cycles_after_rst", cycle_cnt, 32'd0);
`endif
    rst = 1'b0;

    // lw with a stalled fetch and a stalled data read
    instr = 32'h0080A283; mem_ready = 1'b0;
    step("lw_fetch_wait0", F, 0, 0, 3'b000);
    step("lw_fetch_wait1", F, 0, 0, 3'b000);
    mem_ready = 1'b1;
    step("lw_fetch", F, 1, 1, 3'b000);
    step("lw_decode", D, 0, 0, 3'b010);
    mem_ready = 1'b0;
    step("lw_memadr", MA, 0, 0, 3'b000);
    step("lw_memread_w0", MR, 0, 0, 3'b000);
    step("lw_memread_w1", MR, 0, 0, 3'b000);
    mem_ready = 1'b1;
    step("lw_memread", MR, 0, 0, 3'b000);
    step("lw_memwb", MWB, 0, 0, 3'b000);

    // sw with one wait state
    instr = 32'h0020A223;
    step("sw_fetch", F, 1, 1, 3'b000);
    step("sw_decode", D, 0, 0, 3'b010);
    step("sw_memadr", MA, 0, 0, 3'b001);
    mem_ready = 1'b0;
    step("sw_memwrite_w", MW, 0, 0, 3'b000);
    mem_ready = 1'b1;
    step("sw_memwrite", MW, 0, 0, 3'b000);

    // branch polarity table
    for (int k = 0; k < 7; k++) begin
      instr = br_ins[k]; EQ = br_eq[k]; LT = br_lt[k];
      step("br_fetch", F, 1, 1, 3'b000);
      step("br_decode", D, 0, 0, 3'b010);
      step("br_branch", BR, br_tk[k], 0, 3'b000);
    end
    EQ = 1'b0; LT = 1'b0;

    instr = 32'h000000EF;
    step("jal_fetch", F, 1, 1, 3'b000);
    step("jal_decode", D, 0, 0, 3'b100);
    step("jal_jal", JL, 0, 0, 3'b000);
    step("jal_aluwb", AWB, 0, 0, 3'b000);

    instr = 32'h000280E7;
    step("jalr_fetch", F, 1, 1, 3'b000);
    step("jalr_decode", D, 0, 0, 3'b010);
    step("jalr_jalr", JR, 0, 0, 3'b000);
    step("jalr_jal", JL, 0, 0, 3'b000);
    step("jalr_aluwb", AWB, 0, 0, 3'b000);

    instr = 32'h123452B7;
    step("lui_fetch", F, 1, 1, 3'b000);
    step("lui_decode", D, 0, 0, 3'b010);
    step("lui_lui", LU, 0, 0, 3'b000);
    step("lui_aluwb", AWB, 0, 0, 3'b000);

    instr = 32'h12345297;
    step("auipc_fetch", F, 1, 1, 3'b000);
    step("auipc_decode", D, 0, 0, 3'b010);
    step("auipc_auipc", AU, 0, 0, 3'b000);
    step("auipc_aluwb", AWB, 0, 0, 3'b000);

    instr = 32'h00100093;
    step("addi_fetch", F, 1, 1, 3'b000);
    step("addi_decode", D, 0, 0, 3'b010);
    step("addi_execi", XI, 0, 0, 3'b000);
    step("addi_aluwb", AWB, 0, 0, 3'b000);

    // branch with reserved funct3 traps without redirecting the PC
    instr = 32'h0020A063; EQ = 1'b1; LT = 1'b1;
    step("brill_fetch", F, 1, 1, 3'b000);
    step("brill_decode", D, 0, 0, 3'b010);
    step("brill_branch", BR, 0, 0, 3'b000);
    step("brill_trap", TR, 0, 0, 3'b000);
    rst = 1'b1;
    step_rst("brill_reset");
    rst = 1'b0; EQ = 1'b0; LT = 1'b0;

    // illegal opcode: absorbing trap under random mem_ready
    instr = 32'hFFFFFFFF;
    step("ill_fetch", F, 1, 1, 3'b000);
    step("ill_decode", D, 0, 0, 3'b010);
    for (int k = 0; k < 100; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      step("ill_trap_hold", TR, 0, 0, 3'b000);
    end
    rst = 1'b1;
    step_rst("ill_reset");
    rst = 1'b0; mem_ready = 1'b1; instr = 32'h002081B3;
    step("post_trap_fetch", F, 1, 1, 3'b000);
    step("post_trap_decode", D, 0, 0, 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
